// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch input path: default sizes, debounce
// interval and the data-memory IO addresses that expose sw_stable.
package switch_debouncer_pkg;

  localparam int SW_WIDTH_DEFAULT  = 8;
  localparam int DB_CYCLES_DEFAULT = 50000;
  localparam int CNT_WIDTH         = 16;

  // sw_stable[3:0] and sw_stable[7:4] as seen by the data-memory IO read path
  localparam logic [31:0] SW_LOW_ADDR  = 32'hffff_ff60;
  localparam logic [31:0] SW_HIGH_ADDR = 32'hffff_ff64;

endpackage

// File: rtl/switch_debouncer_bit.sv
// One switch bit: two-flop synchronizer, persistence counter, debounced
// level and a one-cycle pulse on each debounced level change.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic toggle
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DB_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic [CNT_WIDTH-1:0] cnt;

  // toggle marks the edge on which level flips; the top uses it for sw_changed
  assign toggle = (s2 != level) && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= toggle;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt < LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        level <= s2;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH board switches independently and keeps a sticky
// "something changed" flag that the IO read path acknowledges.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH     = SW_WIDTH_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             flag_clear,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_edge,
  output logic             sw_changed
);

  logic [WIDTH-1:0] toggle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clock (clock),
      .reset (reset),
      .raw   (sw_raw[i]),
      .level (sw_stable[i]),
      .pulse (sw_edge[i]),
      .toggle(toggle[i])
    );
  end

  // A toggle on the same edge as an acknowledge must not be lost
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_changed <= 1'b0;
    end else if (|toggle) begin
      sw_changed <= 1'b1;
    end else if (flag_clear) begin
      sw_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DB_CYCLES=4; expected values are
// hand-derived from the synchronizer + counter timing.
module tb_switch_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] sw_raw;
  logic       flag_clear;
  logic [7:0] sw_stable;
  logic [7:0] sw_edge;
  logic       sw_changed;

  int total = 0;
  int bad   = 0;

  switch_debouncer #(
    .WIDTH    (8),
    .DB_CYCLES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .flag_clear(flag_clear),
    .sw_stable (sw_stable),
    .sw_edge   (sw_edge),
    .sw_changed(sw_changed)
  );

  always #5 clock = ~clock;

  // Advance one edge and settle just after it; inputs change here too
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] raw, input logic clr, input logic rst);
    sw_raw     = raw;
    flag_clear = clr;
    reset      = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] st, input logic [7:0] ed,
                          input logic ch);
    checkOutput({tag, ".stable"}, sw_stable, st);
    checkOutput({tag, ".edge"}, sw_edge, ed);
    checkOutput({tag, ".changed"}, {7'b0, sw_changed}, {7'b0, ch});
  endtask

  initial begin
    applyStimulus(8'h00, 1'b0, 1'b1);
    tick();
    tick();
    checkAll("reset", 8'h00, 8'h00, 1'b0);

    // Idle after release with switches low
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkAll("idle", 8'h00, 8'h00, 1'b0);
    end

    // Two bits rise together; first sampled at edge 0, stable after edge 5
    applyStimulus(8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkAll("rise_wait", 8'h00, 8'h00, 1'b0);
    end
    tick();
    checkAll("rise_done", 8'h05, 8'h05, 1'b1);
    tick();
    checkAll("rise_after", 8'h05, 8'h00, 1'b1);

    applyStimulus(8'h05, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h05, 1'b0, 1'b0);
    checkAll("clear", 8'h05, 8'h00, 1'b0);

    // Bit2 falls; acknowledge lands on the same edge as the toggle
    applyStimulus(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkAll("fall_wait", 8'h05, 8'h00, 1'b0);
    end
    applyStimulus(8'h01, 1'b1, 1'b0);
    tick();
    checkAll("fall_clr_same", 8'h01, 8'h04, 1'b1);
    tick();
    checkAll("fall_clr_next", 8'h01, 8'h00, 1'b0);

    // Return to all-low and acknowledge
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checkAll("low_again", 8'h00, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("low_clear", {7'b0, sw_changed}, 8'h00);

    // Glitch: bit0 high for three samples is one short of the interval
    applyStimulus(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll("glitch", 8'h00, 8'h00, 1'b0);
    end

    // Bounce on bit7: 1,0,1,0,1 then held; last rising sample is edge 4
    applyStimulus(8'h80, 1'b0, 1'b0);
    tick();
    checkAll("bounce0", 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    checkAll("bounce1", 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    tick();
    checkAll("bounce2", 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    checkAll("bounce3", 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    for (int i = 4; i < 9; i++) begin
      tick();
      checkAll("bounce_hold", 8'h00, 8'h00, 1'b0);
    end
    tick();
    checkAll("bounce_done", 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkAll("bounce_after", 8'h80, 8'h00, 1'b1);
    end

    // Reset mid-count on bit3; bit7 is also high at release and re-debounces
    applyStimulus(8'h88, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(8'h88, 1'b0, 1'b1);
    tick();
    checkAll("mid_reset", 8'h00, 8'h00, 1'b0);
    applyStimulus(8'h88, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkAll("post_reset_wait", 8'h00, 8'h00, 1'b0);
    end
    tick();
    checkAll("post_reset_done", 8'h88, 8'h88, 1'b1);
    tick();
    checkAll("post_reset_after", 8'h88, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of switch bits.
REQ-002 SHALL have parameter DB_CYCLES, default 50000, consecutive cycles a new level must persist; legal range 1..65535.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw_raw  input  WIDTH  asynchronous board switch levels.
REQ-006 SHALL have port flag_clear  input  1  one-cycle acknowledge from the data-memory IO read path; clears sw_changed.
REQ-007 SHALL have port sw_stable  output  WIDTH  debounced levels; drives the data memory's switch_input, where [3:0] is read at 0xffffff60 and [7:4] at 0xffffff64.
REQ-008 SHALL have port sw_edge  output  WIDTH  per-bit one-cycle pulse on a debounced level change.
REQ-009 SHALL have port sw_changed  output  1  sticky flag: some bit changed since the last flag_clear.

Function
REQ-010 SHALL pass each sw_raw bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL keep, per bit, a 16-bit counter cnt and a registered stable level; sw_stable is the vector of these levels.
REQ-012 Per bit, when s2 equals stable, SHALL load cnt with 0.
REQ-013 Per bit, when s2 differs from stable and cnt < DB_CYCLES-1, SHALL increment cnt.
REQ-014 Per bit, when s2 differs from stable and cnt == DB_CYCLES-1, SHALL load stable with s2 and cnt with 0 on the same edge.
REQ-015 Latency: a raw level that is first sampled at edge 0 and held SHALL appear on sw_stable after edge DB_CYCLES+1.
REQ-016 Any return of s2 to the stable level before the count completes SHALL discard progress: cnt goes to 0 and stable is unchanged.
REQ-017 sw_edge[i] SHALL be 1 for exactly the one cycle following the edge at which stable[i] toggled, and 0 otherwise; this covers both rising and falling changes.
REQ-018 sw_changed SHALL be set on any edge at which some stable bit toggles.
REQ-019 sw_changed SHALL be cleared on an edge where flag_clear=1 and no bit toggles.
REQ-020 If a toggle and flag_clear occur on the same edge, set SHALL win.
REQ-021 Bits SHALL be fully independent; simultaneous changes on several bits produce simultaneous sw_edge bits.
REQ-022 cnt SHALL never exceed DB_CYCLES-1; no wrap-around is permitted.

Reset
REQ-023 While reset=1 at an edge, s1, s2, stable, cnt, sw_edge and sw_changed SHALL all load 0. Reset takes priority over all other updates.
REQ-024 Switches that are already high at reset release SHALL be treated as a change: after the full REQ-015 latency they raise sw_stable, sw_edge and sw_changed.
REQ-025 Reset asserted mid-count SHALL abandon the count; after release, the full debounce interval restarts.

Structure
REQ-026 The DB_CYCLES default and the WIDTH default SHALL live in the shared pipeline constants include file. The IO addresses 0xffffff60/0xffffff64 SHALL also be defined there.
REQ-027 SHALL contain one sub-module, debounce_bit (synchronizer, cnt, stable, edge), instantiated WIDTH times by generate.
REQ-028 The top level SHALL hold only the instances and the sw_changed register.

Verification (DB_CYCLES=4)
REQ-029 Reset with sw_raw=0: every output is 0 during reset and for 20 cycles after release.
REQ-030 sw_raw=8'h05 from edge 0 onward:
- sw_stable is 0 through edge 4 and 8'h05 after edge 5.
- sw_edge=8'h05 for exactly one cycle.
- sw_changed=1.
REQ-031 Glitch: bit0 high for 3 cycles, then low: sw_stable, sw_edge and sw_changed stay 0.
REQ-032 Bounce: bit7 sampled 1,0,1,0,1, then held 1: sw_stable[7] rises after edge 5 counted from the last 0->1 sample, and only one sw_edge[7] pulse occurs.
REQ-033 flag_clear asserted on the same edge as a falling debounce of bit2: sw_changed remains 1 and sw_edge=8'h04. flag_clear alone on the next cycle gives sw_changed=0.
REQ-034 Reset mid-operation: bit3 high for 3 cycles, reset for 1 cycle, then released with bit3 still high. sw_stable[3] rises only 5 edges after reset release.
